// File: rtl/ucsbece154b_icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package ucsbece154b_icache_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFill,
    StWrite
  } icacheState_e;

  // Instruction presented whenever the cache cannot supply a valid fetch.
  localparam logic [31:0] NOP = 32'h00000013;

  // Tag width left over after byte, word-offset and index bits are removed.
  function automatic int unsigned tagWidth(int unsigned numSets, int unsigned blockWords);
    return 32 - 2 - $clog2(blockWords) - $clog2(numSets);
  endfunction

endpackage

// File: rtl/ucsbece154b_icache_array.sv
// Valid/tag/data storage: combinational read by index, whole-line write port.
module ucsbece154b_icache_array
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned BLOCK_WORDS = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_SETS),
  localparam int unsigned TAG_W      = tagWidth(NUM_SETS, BLOCK_WORDS),
  localparam int unsigned LINE_W     = BLOCK_WORDS * 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rdIndex,
  output logic              rdValid,
  output logic [TAG_W-1:0]  rdTag,
  output logic [LINE_W-1:0] rdData,
  input  logic              wrEn,
  input  logic [IDX_W-1:0]  wrIndex,
  input  logic [TAG_W-1:0]  wrTag,
  input  logic [LINE_W-1:0] wrData
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  // Valid bits: cleared on reset, set when a line is committed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wrEn) begin
      valid_q[wrIndex] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; a commit overwrites the set unconditionally.
  always_ff @(posedge clk) begin
    if (reset && wrEn) begin
      tag_q[wrIndex]  <= wrTag;
      data_q[wrIndex] <= wrData;
    end
  end

  assign rdValid = valid_q[rdIndex];
  assign rdTag   = tag_q[rdIndex];
  assign rdData  = data_q[rdIndex];

endmodule

// File: rtl/ucsbece154b_icache.sv
// Direct-mapped read-only instruction cache with burst line fill on miss.
module ucsbece154b_icache
  import ucsbece154b_icache_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 8,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF_i,
  input  logic        ReadEnable_i,
  output logic [31:0] InstrF_o,
  output logic        Ready_o,
  output logic [31:0] MemReadAddress_o,
  output logic        MemReadRequest_o,
  input  logic        MemDataReady_i,
  input  logic [31:0] MemDataIn_i
);

  localparam int unsigned OFS_W   = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W   = $clog2(NUM_SETS);
  localparam int unsigned TAG_W   = tagWidth(NUM_SETS, BLOCK_WORDS);
  localparam int unsigned LINE_W  = BLOCK_WORDS * 32;
  localparam int unsigned IDX_LSB = OFS_W + 2;
  localparam int unsigned TAG_LSB = OFS_W + IDX_W + 2;
  localparam logic [OFS_W-1:0] LAST_WORD = OFS_W'(BLOCK_WORDS - 1);

  icacheState_e      state_q;
  logic [OFS_W-1:0]  count_q;
  logic [LINE_W-1:0] lineBuf_q;

  logic [OFS_W-1:0]  pcOffset;
  logic [IDX_W-1:0]  pcIndex;
  logic [TAG_W-1:0]  pcTag;
  logic [IDX_W-1:0]  fillIndex;
  logic [TAG_W-1:0]  fillTag;
  logic              rdValid;
  logic [TAG_W-1:0]  rdTag;
  logic [LINE_W-1:0] rdData;
  logic              hit;
  logic              unusedPcLow;

  assign pcOffset    = PCF_i[IDX_LSB-1:2];
  assign pcIndex     = PCF_i[TAG_LSB-1:IDX_LSB];
  assign pcTag       = PCF_i[31:TAG_LSB];
  assign unusedPcLow = ^PCF_i[1:0];

  // The fill address register doubles as the latched tag/index of the in-flight miss.
  assign fillIndex = MemReadAddress_o[TAG_LSB-1:IDX_LSB];
  assign fillTag   = MemReadAddress_o[31:TAG_LSB];

  ucsbece154b_icache_array #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rdIndex (pcIndex),
    .rdValid (rdValid),
    .rdTag   (rdTag),
    .rdData  (rdData),
    .wrEn    (state_q == StWrite),
    .wrIndex (fillIndex),
    .wrTag   (fillTag),
    .wrData  (lineBuf_q)
  );

  // Combinational lookup; held low while reset is asserted.
  always_comb begin
    hit      = reset && (state_q == StIdle) && ReadEnable_i && rdValid && (rdTag == pcTag);
    Ready_o  = hit;
    InstrF_o = hit ? rdData[{pcOffset, 5'b0} +: 32] : NOP;
  end

  // Miss FSM: request, gather words into the line buffer, then commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= StIdle;
      count_q          <= '0;
      MemReadRequest_o <= 1'b0;
      MemReadAddress_o <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ReadEnable_i && !hit) begin
            state_q          <= StReq;
            MemReadRequest_o <= 1'b1;
            MemReadAddress_o <= {pcTag, pcIndex, {(OFS_W + 2){1'b0}}};
          end
        end
        StReq: begin
          state_q          <= StFill;
          MemReadRequest_o <= 1'b0;
          count_q          <= '0;
        end
        StFill: begin
          if (MemDataReady_i) begin
            lineBuf_q[{count_q, 5'b0} +: 32] <= MemDataIn_i;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_WORD) begin
              state_q <= StWrite;
            end
          end
        end
        StWrite: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Directed self-checking bench for the instruction cache (8 sets x 4 words).
module tb_ucsbece154b_icache;

  logic        clk;
  logic        reset;
  logic [31:0] PCF_i;
  logic        ReadEnable_i;
  logic [31:0] InstrF_o;
  logic        Ready_o;
  logic [31:0] MemReadAddress_o;
  logic        MemReadRequest_o;
  logic        MemDataReady_i;
  logic [31:0] MemDataIn_i;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOPV = 32'h00000013;

  ucsbece154b_icache #(
    .NUM_SETS    (8),
    .BLOCK_WORDS (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PCF_i            (PCF_i),
    .ReadEnable_i     (ReadEnable_i),
    .InstrF_o         (InstrF_o),
    .Ready_o          (Ready_o),
    .MemReadAddress_o (MemReadAddress_o),
    .MemReadRequest_o (MemReadRequest_o),
    .MemDataReady_i   (MemDataReady_i),
    .MemDataIn_i      (MemDataIn_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered in the miss cycle with PCF_i already set to an offset-0 address.
  task automatic missAndFill(input string tag, input logic [31:0] addr,
                             input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
    chk({tag, ".missReady"}, {31'b0, Ready_o}, 32'd0);
    chk({tag, ".missInstr"}, InstrF_o, NOPV);
    chk({tag, ".missReq"}, {31'b0, MemReadRequest_o}, 32'd0);
    step();
    chk({tag, ".reqPulse"}, {31'b0, MemReadRequest_o}, 32'd1);
    chk({tag, ".reqAddr"}, MemReadAddress_o, addr);
    step();
    chk({tag, ".reqDrop"}, {31'b0, MemReadRequest_o}, 32'd0);
    MemDataReady_i = 1'b1;
    MemDataIn_i = w0;
    step();
    MemDataIn_i = w1;
    step();
    MemDataIn_i = w2;
    step();
    MemDataIn_i = w3;
    step();
    MemDataReady_i = 1'b0;
    MemDataIn_i = 32'hDEADBEEF;
    chk({tag, ".writeReady"}, {31'b0, Ready_o}, 32'd0);
    chk({tag, ".writeAddr"}, MemReadAddress_o, addr);
    step();
    chk({tag, ".hitReady"}, {31'b0, Ready_o}, 32'd1);
    chk({tag, ".hitInstr"}, InstrF_o, w0);
  endtask

  initial begin
    bit          rdy [7];
    logic [31:0] gw  [4];
    int          k;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gw  = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};

    reset = 1'b0;
    PCF_i = 32'h0;
    ReadEnable_i = 1'b0;
    MemDataReady_i = 1'b0;
    MemDataIn_i = 32'h0;
    step();
    step();
    chk("rst.ready", {31'b0, Ready_o}, 32'd0);
    chk("rst.req", {31'b0, MemReadRequest_o}, 32'd0);
    chk("rst.addr", MemReadAddress_o, 32'd0);
    chk("rst.instr", InstrF_o, NOPV);
    reset = 1'b1;

    // Cold miss, Ready at cycle 7.
    PCF_i = 32'h00010000;
    ReadEnable_i = 1'b1;
    missAndFill("cold", 32'h00010000, 32'h11111111, 32'h22222222, 32'h33333333,
                32'h44444444);

    // Hits on other offsets of the filled line.
    PCF_i = 32'h0001000C;
    #1;
    chk("hit.off3Ready", {31'b0, Ready_o}, 32'd1);
    chk("hit.off3Instr", InstrF_o, 32'h44444444);
    chk("hit.noReq", {31'b0, MemReadRequest_o}, 32'd0);
    PCF_i = 32'h00010004;
    #1;
    chk("hit.off1Instr", InstrF_o, 32'h22222222);

    // ReadEnable low: no Ready, no fill.
    ReadEnable_i = 1'b0;
    PCF_i = 32'h00050000;
    #1;
    chk("noRe.ready", {31'b0, Ready_o}, 32'd0);
    step();
    chk("noRe.req", {31'b0, MemReadRequest_o}, 32'd0);
    ReadEnable_i = 1'b1;

    // Conflict eviction in set 0.
    PCF_i = 32'h00010080;
    missAndFill("evict", 32'h00010080, 32'hAAAA0000, 32'hAAAA0001, 32'hAAAA0002,
                32'hAAAA0003);
    PCF_i = 32'h00010000;
    #1;
    chk("evict.oldMiss", {31'b0, Ready_o}, 32'd0);
    missAndFill("refill", 32'h00010000, 32'h11111111, 32'h22222222, 32'h33333333,
                32'h44444444);

    // Gapped memory into set 2.
    PCF_i = 32'h00030020;
    #1;
    chk("gap.miss", {31'b0, Ready_o}, 32'd0);
    step();
    chk("gap.reqAddr", MemReadAddress_o, 32'h00030020);
    step();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      MemDataReady_i = rdy[i];
      MemDataIn_i = rdy[i] ? gw[k] : 32'hDEADBEEF;
      #1;
      chk("gap.busy", {31'b0, Ready_o}, 32'd0);
      step();
      if (rdy[i]) k++;
    end
    MemDataReady_i = 1'b0;
    chk("gap.write", {31'b0, Ready_o}, 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      PCF_i = 32'h00030020 + 32'(i * 4);
      #1;
      chk("gap.ready", {31'b0, Ready_o}, 32'd1);
      chk("gap.word", InstrF_o, gw[i]);
    end
    chk("gap.noReq", {31'b0, MemReadRequest_o}, 32'd0);

    // Redirect mid-fill: line 0x00010000 still lands, then new miss at 0x00020010.
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    PCF_i = 32'h00010000;
    #1;
    chk("redir.miss", {31'b0, Ready_o}, 32'd0);
    step();
    chk("redir.reqAddr", MemReadAddress_o, 32'h00010000);
    step();
    MemDataReady_i = 1'b1;
    MemDataIn_i = 32'h51515151;
    step();
    MemDataIn_i = 32'h52525252;
    step();
    PCF_i = 32'h00020010;
    MemDataIn_i = 32'h53535353;
    #1;
    chk("redir.fillReady", {31'b0, Ready_o}, 32'd0);
    step();
    MemDataIn_i = 32'h54545454;
    step();
    MemDataReady_i = 1'b0;
    chk("redir.holdAddr", MemReadAddress_o, 32'h00010000);
    step();
    missAndFill("redir2", 32'h00020010, 32'h61616161, 32'h62626262, 32'h63636363,
                32'h64646464);
    PCF_i = 32'h00010000;
    #1;
    chk("redir.oldLine", InstrF_o, 32'h51515151);
    PCF_i = 32'h0001000C;
    #1;
    chk("redir.oldLine3", InstrF_o, 32'h54545454);

    // Reset mid-fill aborts the line.
    reset = 1'b0;
    step();
    reset = 1'b1;
    PCF_i = 32'h00010000;
    step();
    chk("rstFill.req", {31'b0, MemReadRequest_o}, 32'd1);
    step();
    MemDataReady_i = 1'b1;
    MemDataIn_i = 32'h99999991;
    step();
    MemDataIn_i = 32'h99999992;
    step();
    reset = 1'b0;
    MemDataIn_i = 32'h99999993;
    #1;
    chk("rstFill.heldReady", {31'b0, Ready_o}, 32'd0);
    step();
    MemDataIn_i = 32'h99999994;
    chk("rstFill.addr", MemReadAddress_o, 32'd0);
    chk("rstFill.reqLow", {31'b0, MemReadRequest_o}, 32'd0);
    step();
    reset = 1'b1;
    MemDataReady_i = 1'b0;
    missAndFill("rstFill", 32'h00010000, 32'h77777771, 32'h77777772, 32'h77777773,
                32'h77777774);
    PCF_i = 32'h00010008;
    #1;
    chk("rstFill.word2", InstrF_o, 32'h77777773);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_icache.md
Name: ucsbece154b_icache

Overview:
- Direct-mapped, read-only instruction cache between the fetch-stage PC register and main memory.
- Supplies InstrF to the pipelined datapath in the same cycle as PCF on a hit.
- On a miss it deasserts Ready_o (hazard logic turns this into StallF/StallD), runs a burst line fill from memory, then resumes.

Parameters:
- NUM_SETS, 8, number of lines; power of 2, ≥2.
- BLOCK_WORDS, 4, 32-bit words per line; power of 2, ≥2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- PCF_i  input  32  fetch address; bits [1:0] ignored
- ReadEnable_i  input  1  fetch request valid this cycle
- InstrF_o  output  32  instruction for PCF_i; 32'h00000013 (NOP) whenever Ready_o=0
- Ready_o  output  1  1 = InstrF_o valid for current PCF_i
- MemReadAddress_o  output  32  line-aligned fill address
- MemReadRequest_o  output  1  one-cycle fill request pulse
- MemDataReady_i  input  1  MemDataIn_i carries the next fill word
- MemDataIn_i  input  32  fill data; words in ascending order starting at offset 0

Behaviour:
- Address split: offset = PCF_i[OFS_MSB:2], OFS_MSB = 1+log2(BLOCK_WORDS); index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Storage per set: valid bit, tag, BLOCK_WORDS data words.
- Lookup is combinational:
  - hit = state IDLE & ReadEnable_i & valid[index] & tag match.
  - Ready_o = hit; InstrF_o = data[index][offset] on hit.
  - Ready_o=0 in any non-IDLE state.
- States:
  - IDLE: on ReadEnable_i & !hit, latch tag/index, go to REQ.
  - REQ (1 cycle): MemReadRequest_o=1, MemReadAddress_o = {tag,index,zero offset}, word counter=0, go to FILL.
  - FILL: each cycle with MemDataReady_i=1, write MemDataIn_i into line buffer[counter] and increment counter.
    - Cycles with MemDataReady_i=0 are gaps; stay and hold.
    - After word BLOCK_WORDS-1 is captured, go to WRITE.
  - WRITE (1 cycle): commit buffer, latched tag and valid=1 into the set; go to IDLE.
- MemReadRequest_o is 0 in every state except REQ. MemReadAddress_o holds its value from REQ through WRITE.
- Miss latency: miss detected in cycle 0; REQ in cycle 1; fill words follow; WRITE; hit re-evaluated the cycle after WRITE.
  - With zero-gap memory the first word arrives at cycle 2 at the earliest. BLOCK_WORDS=4, no gaps → Ready_o=1 at cycle 7.
- PCF_i changes during REQ/FILL/WRITE (e.g. a branch redirect): the in-flight fill completes unchanged for the latched address. The IDLE lookup afterwards uses the current PCF_i and may miss again.
- MemDataReady_i while IDLE/REQ/WRITE: ignored.
- Same-set conflict: a fill overwrites the set unconditionally; no replacement policy.
- ReadEnable_i=0 in IDLE: Ready_o=0, no fill started.
- Reset (reset=0 at a rising edge):
  - All valid bits cleared, state=IDLE, counter=0.
  - MemReadRequest_o=0, MemReadAddress_o=0; Ready_o=0 while reset is held.
  - Reset mid-fill aborts: no line written, later fill words ignored. Memory is reset by the same signal.
  - Data and tag arrays are not reset.

Decomposition:
- Shared package/defines: state encodings (IDLE, REQ, FILL, WRITE), NOP constant 32'h00000013, derived widths (OFS_W, IDX_W, TAG_W via $clog2).
- One natural sub-module: ucsbece154b_icache_array. It holds valid/tag/data storage, has a combinational read port (index) and a single write port committing a full line.

Test Plan:
- Cold miss: reset, then PCF=0x00010000, ReadEnable=1. Expect Ready=0, InstrF=0x00000013, MemReadRequest pulse with address 0x00010000. Feed 0x11111111..0x44444444 with no gaps. Expect Ready=1 at cycle 7, InstrF=0x11111111.
- Hit after fill: PCF=0x0001000C the cycle after fill. Expect Ready=1, InstrF=0x44444444 same cycle, no MemReadRequest.
- Conflict eviction: fetch 0x00010000 (fill), then 0x00010080 (same index 0, different tag). Expect a second request at 0x00010080. Refetch 0x00010000 → miss again.
- Gapped memory: during fill, MemDataReady pattern 1,0,0,1,1,0,1. Expect words captured only on ready cycles, exactly one WRITE, correct data at all 4 offsets.
- Redirect mid-fill: PCF changes 0x00010000→0x00020010 during FILL. Expect line 0x00010000 filled. Next cycle: new miss, request at 0x00020010.
- Reset mid-fill: reset=0 after 2 fill words, then release and refetch 0x00010000. Expect a fresh request with no stale hit, and Ready=0 until the new fill completes.
